// File: rtl/csel_pipe_adder_pkg.sv
// rtl/csel_pipe_adder_pkg.sv - shared defaults and width helper for the carry-select pipeline adder
package csel_pipe_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

  function automatic bit seg_divides(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/csel_pipe_adder_if.sv
// rtl/csel_pipe_adder_if.sv - operand-in / result-out handshake bundle
interface csel_pipe_adder_if
  import csel_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/csel_mux2.sv
// rtl/csel_mux2.sv - single-bit 2:1 multiplexor used by the carry-select banks
module csel_mux2 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/csel_pipe_adder_segment.sv
// rtl/csel_pipe_adder_segment.sv - combinational carry-select segment: two ripple adders and a mux bank
module csel_segment
  import csel_pipe_adder_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           cin_sel,
  output logic [SEG-1:0] sum_seg,
  output logic           cout_seg
);

  logic [SEG:0]   c0;
  logic [SEG:0]   c1;
  logic [SEG-1:0] s0;
  logic [SEG-1:0] s1;

  // Both candidates ripple independently; the registered carry only picks one.
  always_comb begin
    c0    = '0;
    c1    = '0;
    s0    = '0;
    s1    = '0;
    c0[0] = 1'b0;
    c1[0] = 1'b1;
    for (int i = 0; i < SEG; i++) begin
      s0[i]   = a_seg[i] ^ b_seg[i] ^ c0[i];
      c0[i+1] = (a_seg[i] & b_seg[i]) | (c0[i] & (a_seg[i] ^ b_seg[i]));
      s1[i]   = a_seg[i] ^ b_seg[i] ^ c1[i];
      c1[i+1] = (a_seg[i] & b_seg[i]) | (c1[i] & (a_seg[i] ^ b_seg[i]));
    end
  end

  for (genvar i = 0; i < SEG; i++) begin : g_sum_mux
    csel_mux2 u_mux (
      .d0  (s0[i]),
      .d1  (s1[i]),
      .sel (cin_sel),
      .y   (sum_seg[i])
    );
  end

  csel_mux2 u_cout_mux (
    .d0  (c0[SEG]),
    .d1  (c1[SEG]),
    .sel (cin_sel),
    .y   (cout_seg)
  );

endmodule

// File: rtl/csel_pipe_adder.sv
// rtl/csel_pipe_adder.sv - pipelined carry-select adder, one SEG-bit segment per stage, global stall
module csel_pipe_adder
  import csel_pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic              clk,
  input  logic              rst_n,
  csel_pipe_adder_if.slave  bus
);

  localparam int STAGES = WIDTH / SEG;

  if (!seg_divides(WIDTH, SEG)) begin : g_width_check
    $error("csel_pipe_adder: WIDTH must be a non-zero multiple of SEG");
  end

  logic en;

  logic [STAGES:1]  valid_q;
  logic [STAGES:1]  valid_d;
  logic [STAGES:1]  carry_q;
  logic [STAGES:1]  carry_d;
  logic [WIDTH-1:0] sum_q [1:STAGES];
  logic [WIDTH-1:0] sum_d [1:STAGES];
  logic [WIDTH-1:0] a_q   [1:STAGES];
  logic [WIDTH-1:0] a_d   [1:STAGES];
  logic [WIDTH-1:0] b_q   [1:STAGES];
  logic [WIDTH-1:0] b_d   [1:STAGES];

  logic [STAGES-1:0] vin_s;
  logic [STAGES-1:0] cin_s;
  logic [WIDTH-1:0]  a_s   [0:STAGES-1];
  logic [WIDTH-1:0]  b_s   [0:STAGES-1];
  logic [WIDTH-1:0]  sum_s [0:STAGES-1];
  logic [SEG-1:0]    seg_sum  [0:STAGES-1];
  logic [STAGES-1:0] seg_cout;

  // Stage 0 reads the ports; every later stage reads the register in front of it.
  always_comb begin
    vin_s    = '0;
    cin_s    = '0;
    vin_s[0] = bus.in_valid;
    cin_s[0] = bus.cin;
    a_s[0]   = bus.a;
    b_s[0]   = bus.b;
    sum_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      vin_s[k] = valid_q[k];
      cin_s[k] = carry_q[k];
      a_s[k]   = a_q[k];
      b_s[k]   = b_q[k];
      sum_s[k] = sum_q[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    csel_segment #(.SEG(SEG)) u_seg (
      .a_seg    (a_s[k][SEG*k +: SEG]),
      .b_seg    (b_s[k][SEG*k +: SEG]),
      .cin_sel  (cin_s[k]),
      .sum_seg  (seg_sum[k]),
      .cout_seg (seg_cout[k])
    );
  end

  always_comb begin
    valid_d = '0;
    carry_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k+1]              = vin_s[k];
      carry_d[k+1]              = seg_cout[k];
      sum_d[k+1]                = sum_s[k];
      sum_d[k+1][SEG*k +: SEG]  = seg_sum[k];
      a_d[k+1]                  = a_s[k];
      b_d[k+1]                  = b_s[k];
    end
  end

  // One enable for the whole pipe: bubbles travel with the data rather than collapsing.
  assign en = !valid_q[STAGES] || bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else if (en) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      for (int k = 1; k <= STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
    end
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = valid_q[STAGES];
  assign bus.sum       = sum_q[STAGES];
  assign bus.cout      = carry_q[STAGES];

endmodule
